// File: rtl/pip_cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pip_cpu_pkg
//  Purpose  : Shared constants and types for the pipelined MIPS CPU front end:
//             PCSrc encodings, the NOP word, instruction field ranges, the
//             fetch FSM state type and the redirect-target helper.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package pip_cpu_pkg;

    // PCSrc encodings produced by the decode-stage control unit
    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_J   = 2'b10;
    localparam logic [1:0] PCSRC_JR  = 2'b11;

    // sll $0,$0,0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Instruction field ranges
    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 26;
    localparam int FUNC_HI   = 5;
    localparam int FUNC_LO   = 0;
    localparam int RT_HI     = 20;
    localparam int RT_LO     = 16;
    localparam int IMM_HI    = 15;
    localparam int IMM_LO    = 0;
    localparam int INDEX_HI  = 25;
    localparam int INDEX_LO  = 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_t;

    // Redirect target for the instruction held in IF/ID. The result is always
    // word aligned; arithmetic wraps naturally at 32 bits.
    function automatic logic [31:0] redirect_target(
        input logic [1:0]  sel,
        input logic [31:0] instr,
        input logic [31:0] pc4,
        input logic [31:0] jr
    );
        logic [31:0] t;
        case (sel)
            PCSRC_BR: t = pc4 + {{14{instr[IMM_HI]}}, instr[IMM_HI:IMM_LO], 2'b00};
            PCSRC_J:  t = {pc4[31:28], instr[INDEX_HI:INDEX_LO], 2'b00};
            PCSRC_JR: t = jr;
            default:  t = pc4;
        endcase
        return t & 32'hFFFF_FFFC;
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : if_stage_if
//  Purpose  : Instruction-memory request/response bus between the fetch
//             stage (master) and the instruction memory (slave).
//  Signals  : req    - one-cycle request pulse, addr valid while high
//             addr   - word-aligned fetch address
//             rvalid - response strobe, one per request, >=1 cycle later
//             rdata  - instruction word, valid with rvalid
//  Revision : 1.0  initial release
// ============================================================================
interface if_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, output addr, input rvalid, input rdata);
    modport slave  (input req, input addr, output rvalid, output rdata);
endinterface
`default_nettype wire

// File: rtl/if_stage_id_reg.sv
`default_nettype none
// ============================================================================
//  Module   : if_id_reg
//  Purpose  : IF/ID pipeline register. Priority: hold > load > squash.
//  Ports    : clk, rst       - clock, synchronous active-high reset
//             load_i         - capture instr_i/pc4_i as a live instruction
//             hold_i         - keep current contents (pipeline stall)
//             squash_i       - replace contents with a NOP bubble
//             instr_i, pc4_i - incoming instruction and its address + 4
//             valid_o, instr_o, pc4_o - register contents
//  Revision : 1.0  initial release
// ============================================================================
module if_id_reg #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        load_i,
    input  wire logic        hold_i,
    input  wire logic        squash_i,
    input  wire logic [31:0] instr_i,
    input  wire logic [31:0] pc4_i,
    output logic             valid_o,
    output logic [31:0]      instr_o,
    output logic [31:0]      pc4_o
);
    logic        valid_q;
    logic [31:0] instr_q;
    logic [31:0] pc4_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'h0000_0000;
        end else if (hold_i) begin
            valid_q <= valid_q;
        end else if (load_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            pc4_q   <= pc4_i;
        end else if (squash_i) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc4_o   = pc4_q;
endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module   : if_stage
//  Purpose  : Fetch stage of the pipelined MIPS CPU. Holds the PC, issues
//             one outstanding instruction-memory request at a time, owns the
//             IF/ID register and redirects on the decode-stage PCSrc.
//  Ports    : clk, rst    - clock, synchronous active-high reset
//             stall       - hold PC and IF/ID this cycle
//             pc_src      - 00 seq, 01 branch, 10 j/jal, 11 jr/jalr
//             jr_target   - forwarded rs value for jr/jalr
//             imem        - instruction-memory bus (master side)
//             id_valid, id_instr, id_pc4 - IF/ID contents
//             id_opcode, id_func, id_rt  - decode fields of id_instr
//  Config   : IF_DELAY_SLOT_EN - when defined, the instruction after a taken
//             branch/jump executes (delay slot) and the target is fetched
//             after it; otherwise that instruction is squashed.
//  Revision : 1.0  initial release
// ============================================================================
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        stall,
    input  wire logic [1:0]  pc_src,
    input  wire logic [31:0] jr_target,
    if_stage_if.master       imem,
    output logic             id_valid,
    output logic [31:0]      id_instr,
    output logic [31:0]      id_pc4,
    output logic [5:0]       id_opcode,
    output logic [5:0]       id_func,
    output logic [4:0]       id_rt
);
    import pip_cpu_pkg::*;

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;           // address of the outstanding fetch
    logic [31:0]  hold_instr_q, hold_instr_d;
    logic [31:0]  hold_pc4_q, hold_pc4_d;

    logic         req;
    logic [31:0]  addr;
    logic         ld;
    logic [31:0]  ld_instr;
    logic [31:0]  ld_pc4;

    logic         redirect;
    logic [31:0]  target;
    logic [31:0]  pc_plus4;
    logic [31:0]  seq_pc;

    assign redirect = id_valid & ~stall & (pc_src != PCSRC_SEQ);
    assign target   = redirect_target(pc_src, id_instr, id_pc4, jr_target);
    assign pc_plus4 = pc_q + 32'd4;

`ifdef IF_DELAY_SLOT_EN
    // Target of a branch seen before its delay slot returned from memory
    logic         pend_valid_q, pend_valid_d;
    logic [31:0]  pend_pc_q, pend_pc_d;
    assign seq_pc = pend_valid_q ? pend_pc_q : pc_plus4;
`else
    assign seq_pc = pc_plus4;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            hold_instr_q <= NOP_INSTR;
            hold_pc4_q   <= 32'h0000_0000;
`ifdef IF_DELAY_SLOT_EN
            pend_valid_q <= 1'b0;
            pend_pc_q    <= 32'h0000_0000;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            hold_instr_q <= hold_instr_d;
            hold_pc4_q   <= hold_pc4_d;
`ifdef IF_DELAY_SLOT_EN
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hold_instr_d = hold_instr_q;
        hold_pc4_d   = hold_pc4_q;
        req          = 1'b0;
        addr         = pc_q;
        ld           = 1'b0;
        ld_instr     = imem.rdata;
        ld_pc4       = pc_plus4;
`ifdef IF_DELAY_SLOT_EN
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;
`endif
        case (state_q)
            S_IDLE: begin
                req     = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem.rvalid) begin
                    if (redirect) begin
`ifdef IF_DELAY_SLOT_EN
                        // Returning word is the delay slot: keep it
                        ld           = 1'b1;
                        pend_valid_d = 1'b0;
`endif
                        pc_d = target;
                        req  = 1'b1;
                        addr = target;
                    end else if (stall) begin
                        hold_instr_d = imem.rdata;
                        hold_pc4_d   = pc_plus4;
                        state_d      = S_HOLD;
                    end else begin
                        ld   = 1'b1;
                        pc_d = seq_pc;
                        req  = 1'b1;
                        addr = seq_pc;
`ifdef IF_DELAY_SLOT_EN
                        pend_valid_d = 1'b0;
`endif
                    end
                end else if (redirect) begin
`ifdef IF_DELAY_SLOT_EN
                    pend_valid_d = 1'b1;
                    pend_pc_d    = target;
`else
                    // The in-flight word is wrong-path; skip it in DROP
                    pc_d    = target;
                    state_d = S_DROP;
`endif
                end
            end
            S_DROP: begin
                if (imem.rvalid) begin
                    req     = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_HOLD: begin
                if (redirect) begin
`ifdef IF_DELAY_SLOT_EN
                    ld           = 1'b1;
                    ld_instr     = hold_instr_q;
                    ld_pc4       = hold_pc4_q;
                    pend_valid_d = 1'b0;
`endif
                    pc_d    = target;
                    req     = 1'b1;
                    addr    = target;
                    state_d = S_WAIT;
                end else if (!stall) begin
                    ld       = 1'b1;
                    ld_instr = hold_instr_q;
                    ld_pc4   = hold_pc4_q;
                    pc_d     = seq_pc;
                    req      = 1'b1;
                    addr     = seq_pc;
                    state_d  = S_WAIT;
`ifdef IF_DELAY_SLOT_EN
                    pend_valid_d = 1'b0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Reset overrides the IDLE request so the bus is quiet while rst is high
    assign imem.req  = req & ~rst;
    assign imem.addr = addr;

    // When no new word is loaded and the pipe is not stalled, the ID slot
    // empties so a consumed instruction is never presented to decode twice;
    // this also covers the squash on a redirect.
    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .load_i   (ld),
        .hold_i   (stall),
        .squash_i (~ld),
        .instr_i  (ld_instr),
        .pc4_i    (ld_pc4),
        .valid_o  (id_valid),
        .instr_o  (id_instr),
        .pc4_o    (id_pc4)
    );

    assign id_opcode = id_instr[OPCODE_HI:OPCODE_LO];
    assign id_func   = id_instr[FUNC_HI:FUNC_LO];
    assign id_rt     = id_instr[RT_HI:RT_LO];
endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_stage
//  Purpose  : Directed self-checking bench for if_stage with a behavioural
//             instruction memory of programmable latency (mem[a] = a, except
//             a few hand-placed branch/jump words).
//  Revision : 1.0  initial release
// ============================================================================
module tb_if_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic [1:0]  pc_src = 2'b00;
    logic [31:0] jr_target = 32'h0;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;
    logic [5:0]  id_opcode;
    logic [5:0]  id_func;
    logic [4:0]  id_rt;

    int n_assert = 0;
    int n_fail   = 0;
    int lat      = 1;

    if_stage_if imem ();

    if_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .pc_src    (pc_src),
        .jr_target (jr_target),
        .imem      (imem.master),
        .id_valid  (id_valid),
        .id_instr  (id_instr),
        .id_pc4    (id_pc4),
        .id_opcode (id_opcode),
        .id_func   (id_func),
        .id_rt     (id_rt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        case (a)
            32'h0000_000C: return 32'h1000_0003;   // beq, imm = 3
            32'h0040_0004: return 32'h0800_0100;   // j index 0x100
            default:       return a;
        endcase
    endfunction

    // Single-outstanding memory, response 'lat' cycles after the request
    logic        m_busy = 1'b0;
    int          m_cnt  = 0;
    logic [31:0] m_addr = 32'h0;
    initial begin
        imem.rvalid = 1'b0;
        imem.rdata  = 32'h0;
    end
    always @(posedge clk) begin
        if (rst) begin
            m_busy      <= 1'b0;
            imem.rvalid <= 1'b0;
        end else if (imem.req) begin
            if (lat == 1) begin
                imem.rvalid <= 1'b1;
                imem.rdata  <= memf(imem.addr);
                m_busy      <= 1'b0;
            end else begin
                imem.rvalid <= 1'b0;
                m_busy      <= 1'b1;
                m_cnt       <= lat - 1;
                m_addr      <= imem.addr;
            end
        end else if (m_busy) begin
            if (m_cnt == 1) begin
                imem.rvalid <= 1'b1;
                imem.rdata  <= memf(m_addr);
                m_busy      <= 1'b0;
            end else begin
                imem.rvalid <= 1'b0;
                m_cnt       <= m_cnt - 1;
            end
        end else begin
            imem.rvalid <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_on(input int l);
        lat       = l;
        rst       = 1'b1;
        stall     = 1'b0;
        pc_src    = 2'b00;
        jr_target = 32'h0;
        repeat (3) tick();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // ---------------- reset state, 1-cycle memory ----------------
        reset_on(1);
        #2;
        chk("rst_req",    imem.req, 0);
        chk("rst_valid",  id_valid, 0);
        chk("rst_instr",  id_instr, 32'h0);
        chk("rst_pc4",    id_pc4,   32'h0);

        // ---------------- sequential fetch ----------------
        tick(); rst = 1'b0; #2;                        // cycle 0
        chk("t1_c0_req",   imem.req,  1);
        chk("t1_c0_addr",  imem.addr, 32'h0);
        chk("t1_c0_valid", id_valid,  0);
        tick(); #2;                                    // cycle 1
        chk("t1_c1_addr",  imem.addr, 32'h4);
        chk("t1_c1_valid", id_valid,  0);
        tick(); #2;                                    // cycle 2
        chk("t1_c2_addr",  imem.addr, 32'h8);
        chk("t1_c2_valid", id_valid,  1);
        chk("t1_c2_pc4",   id_pc4,    32'h4);
        tick(); #2;                                    // cycle 3
        chk("t1_c3_addr",  imem.addr, 32'hC);
        chk("t1_c3_pc4",   id_pc4,    32'h8);
        chk("t1_c3_instr", id_instr,  32'h4);
        tick(); #2;                                    // cycle 4
        chk("t1_c4_addr",  imem.addr, 32'h10);
        chk("t1_c4_pc4",   id_pc4,    32'hC);

        // ---------------- beq taken, imm 3 from id_pc4 0x10 ----------------
        tick(); pc_src = 2'b01; #2;                    // cycle 5
        chk("t3_instr",  id_instr,  32'h1000_0003);
        chk("t3_opcode", id_opcode, 32'h4);
        chk("t3_pc4",    id_pc4,    32'h10);
        chk("t3_req",    imem.req,  1);
        chk("t3_addr",   imem.addr, 32'h1C);
        tick(); pc_src = 2'b00; #2;                    // cycle 6
`ifdef IF_DELAY_SLOT_EN
        chk("t7_slot_valid", id_valid, 1);
        chk("t7_slot_instr", id_instr, 32'h10);
`else
        chk("t3_sq_valid", id_valid, 0);
        chk("t3_sq_instr", id_instr, 32'h0);
`endif
        chk("t3_c6_addr", imem.addr, 32'h20);
        tick(); #2;                                    // cycle 7
        chk("t3_tgt_instr", id_instr, 32'h1C);
        chk("t3_tgt_pc4",   id_pc4,   32'h20);

        // ---------------- jr to 0x400004, then j with stall ----------------
        pc_src = 2'b11; jr_target = 32'h0040_0004; #1;
        chk("t4_jr_addr", imem.addr, 32'h0040_0004);
        tick(); pc_src = 2'b00; #2;                    // cycle 8
`ifdef IF_DELAY_SLOT_EN
        chk("t4_c8_valid", id_valid, 1);
`else
        chk("t4_c8_valid", id_valid, 0);
`endif
        chk("t4_c8_addr", imem.addr, 32'h0040_0008);
        tick(); stall = 1'b1; pc_src = 2'b10; #2;      // cycle 9
        chk("t4_j_instr",    id_instr, 32'h0800_0100);
        chk("t4_j_pc4",      id_pc4,   32'h0040_0008);
        chk("t4_stall_req",  imem.req, 0);
        tick(); stall = 1'b0; #2;                      // cycle 10
        chk("t4_hold_instr", id_instr,  32'h0800_0100);
        chk("t4_j_req",      imem.req,  1);
        chk("t4_j_addr",     imem.addr, 32'h0000_0400);
        tick(); pc_src = 2'b00; #2;                    // cycle 11
`ifdef IF_DELAY_SLOT_EN
        chk("t4_c11_valid", id_valid, 1);
        chk("t4_c11_instr", id_instr, 32'h0040_0008);
`else
        chk("t4_c11_valid", id_valid, 0);
`endif
        chk("t4_c11_addr", imem.addr, 32'h404);
        tick(); #2;                                    // cycle 12
        chk("t4_c12_instr", id_instr, 32'h400);
        chk("t4_c12_pc4",   id_pc4,   32'h404);

        // ---------------- stall 3 cycles as rvalid arrives ----------------
        reset_on(1);
        tick(); rst = 1'b0; #2;                        // cycle 0
        tick(); #2;                                    // cycle 1
        tick(); stall = 1'b1; #2;                      // cycle 2
        chk("t2_c2_req", imem.req, 0);
        tick(); #2;                                    // cycle 3
        chk("t2_c3_req",   imem.req, 0);
        chk("t2_c3_instr", id_instr, 32'h0);
        chk("t2_c3_pc4",   id_pc4,   32'h4);
        tick(); #2;                                    // cycle 4
        chk("t2_c4_req",   imem.req, 0);
        chk("t2_c4_pc4",   id_pc4,   32'h4);
        tick(); stall = 1'b0; #2;                      // cycle 5
        chk("t2_rel_req",  imem.req,  1);
        chk("t2_rel_addr", imem.addr, 32'h8);
        tick(); #2;                                    // cycle 6
        chk("t2_c6_instr", id_instr, 32'h4);
        chk("t2_c6_pc4",   id_pc4,   32'h8);
        tick(); #2;                                    // cycle 7
        chk("t2_c7_instr", id_instr, 32'h8);

        // ---------------- latency 3, jr while a fetch is outstanding ----------------
        reset_on(3);
        tick(); rst = 1'b0; #2;                        // cycle 0
        tick(); tick(); tick(); #2;                    // cycle 3
        chk("t5_c3_addr", imem.addr, 32'h4);
        tick(); pc_src = 2'b11; jr_target = 32'h2000; #2;   // cycle 4
        chk("t5_c4_valid", id_valid, 1);
        chk("t5_c4_req",   imem.req, 0);
        tick(); pc_src = 2'b00; #2;                    // cycle 5
        chk("t5_c5_valid", id_valid, 0);
        tick(); #2;                                    // cycle 6
        chk("t5_c6_req",  imem.req,  1);
        chk("t5_c6_addr", imem.addr, 32'h2000);
        tick(); #2;                                    // cycle 7
`ifdef IF_DELAY_SLOT_EN
        chk("t5_c7_valid", id_valid, 1);
        chk("t5_c7_instr", id_instr, 32'h4);
`else
        chk("t5_c7_valid", id_valid, 0);
`endif
        tick(); tick(); tick(); #2;                    // cycle 10
        chk("t5_c10_instr", id_instr, 32'h2000);
        chk("t5_c10_pc4",   id_pc4,   32'h2004);

        // ---------------- reset in WAIT ----------------
        reset_on(3);
        tick(); rst = 1'b0; #2;                        // cycle 0
        tick(); rst = 1'b1; #2;                        // cycle 1
        chk("t6w_c1_req", imem.req, 0);
        tick(); #2;                                    // cycle 2
        chk("t6w_req",   imem.req, 0);
        chk("t6w_valid", id_valid, 0);
        tick(); rst = 1'b0; #2;                        // cycle 3
        chk("t6w_rel_req",  imem.req,  1);
        chk("t6w_rel_addr", imem.addr, 32'h0);

        // ---------------- reset in HOLD ----------------
        reset_on(1);
        tick(); rst = 1'b0; #2;                        // cycle 0
        tick(); #2;                                    // cycle 1
        tick(); stall = 1'b1; #2;                      // cycle 2
        tick(); rst = 1'b1; #2;                        // cycle 3
        chk("t6h_c3_valid", id_valid, 1);
        tick(); #2;                                    // cycle 4
        chk("t6h_req",   imem.req, 0);
        chk("t6h_valid", id_valid, 0);
        chk("t6h_instr", id_instr, 32'h0);
        chk("t6h_pc4",   id_pc4,   32'h0);
        tick(); rst = 1'b0; stall = 1'b0; #2;          // cycle 5
        chk("t6h_rel_req",  imem.req,  1);
        chk("t6h_rel_addr", imem.addr, 32'h0);
        tick(); #2;                                    // cycle 6
        chk("t6h_c6_addr",  imem.addr, 32'h4);
        chk("t6h_c6_valid", id_valid,  0);
        tick(); #2;                                    // cycle 7
        chk("t6h_c7_valid", id_valid, 1);
        chk("t6h_c7_pc4",   id_pc4,   32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
